// File: rtl/prog_delay_line.sv
// Programmable delay line: each accepted sample is delayed by N (1..MAX_N) accepted samples
// through a circular buffer. Output is suppressed until N samples have been collected.
module prog_delay_line #(
  parameter int DW     = 16,
  parameter int MAX_N  = 64,
  parameter int NW     = 7,
  parameter int N_INIT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] din,
  input  logic          load,
  input  logic [NW-1:0] delay_sel,
  input  logic          flush,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          primed
);
  localparam int AW = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  typedef enum logic [1:0] {EMPTY, FILL, RUN} state_t;

  state_t        state_q, state_d;
  logic [NW-1:0] n_q, n_d;
  logic [NW-1:0] fill_q, fill_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic [DW-1:0] mem_q [MAX_N];
  logic [NW:0]   rd_sum;
  logic [AW-1:0] rd_addr;
  logic          restart;

  function automatic logic [NW-1:0] clamp_delay(input logic [NW-1:0] sel);
    logic [NW-1:0] r;
    r = sel;
    if (sel == '0)
      r = NW'(1);
    else if (sel > NW'(MAX_N))
      r = NW'(MAX_N);
    return r;
  endfunction

  // Read address (wr_ptr - N) mod MAX_N, biased by MAX_N to stay non-negative.
  always_comb begin
    rd_sum = (NW+1)'(wr_ptr_q) + (NW+1)'(MAX_N) - {1'b0, n_q};
    if (rd_sum >= (NW+1)'(MAX_N))
      rd_addr = AW'(rd_sum - (NW+1)'(MAX_N));
    else
      rd_addr = AW'(rd_sum);
  end

  assign restart = load | flush;

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    fill_d       = fill_q;
    wr_ptr_d     = wr_ptr_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;

    if (load)
      n_d = clamp_delay(delay_sel);

    if (en)
      wr_ptr_d = (wr_ptr_q == AW'(MAX_N - 1)) ? '0 : wr_ptr_q + AW'(1);

    if (restart) begin
      // A coincident sample is kept as the first sample of the new fill.
      if (en) begin
        fill_d  = NW'(1);
        state_d = (n_d == NW'(1)) ? RUN : FILL;
      end else begin
        fill_d  = '0;
        state_d = EMPTY;
      end
    end else if (en) begin
      if (state_q == RUN) begin
        dout_d       = mem_q[rd_addr];
        dout_valid_d = 1'b1;
      end else begin
        fill_d  = fill_q + NW'(1);
        state_d = (fill_d == n_q) ? RUN : FILL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      n_q          <= NW'(N_INIT);
      fill_q       <= '0;
      wr_ptr_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      fill_q       <= fill_d;
      wr_ptr_q     <= wr_ptr_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // Sample storage carries no reset; fill tracking keeps stale entries from being emitted.
  always_ff @(posedge clk) begin
    if (en)
      mem_q[wr_ptr_q] <= din;
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign primed     = (state_q == RUN);

endmodule

// File: tb/tb_prog_delay_line.sv
// Bench for prog_delay_line: directed scenarios with literal expectations plus a randomized
// phase, all outputs compared every cycle against a sample-history reference model.
module tb_prog_delay_line;
  localparam int DW = 16;
  localparam int MAX_N = 64;
  localparam int NW = 7;
  localparam int N_INIT = 64;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [DW-1:0] din;
  logic          load;
  logic [NW-1:0] delay_sel;
  logic          flush;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          primed;

  int total = 0;
  int bad = 0;
  bit chk = 0;

  prog_delay_line #(.DW(DW), .MAX_N(MAX_N), .NW(NW), .N_INIT(N_INIT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .load(load),
    .delay_sel(delay_sel), .flush(flush), .dout(dout),
    .dout_valid(dout_valid), .primed(primed)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Reference model: history of samples accepted since the last restart.
  logic [DW-1:0] hist[$];
  int            n_m;
  logic [DW-1:0] exp_dout;
  logic          exp_vld;
  logic          exp_primed;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      n_m = N_INIT;
      exp_dout = '0;
      exp_vld = 0;
      exp_primed = 0;
    end else begin
      exp_vld = 0;
      if (load)
        n_m = (delay_sel == 0) ? 1 : ((int'(delay_sel) > MAX_N) ? MAX_N : int'(delay_sel));
      if (load || flush) begin
        hist.delete();
        if (en) hist.push_back(din);
      end else if (en) begin
        if (hist.size() >= n_m) begin
          exp_dout = hist[hist.size() - n_m];
          exp_vld = 1;
        end
        hist.push_back(din);
        if (hist.size() > MAX_N) void'(hist.pop_front());
      end
      exp_primed = (hist.size() >= n_m);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      check("model_dout_valid", 32'(dout_valid), 32'(exp_vld));
      check("model_dout", 32'(dout), 32'(exp_dout));
      check("model_primed", 32'(primed), 32'(exp_primed));
    end
  end

  task automatic cyc(input logic e, input logic [DW-1:0] d, input logic ld,
                     input logic fl, input logic [NW-1:0] s);
    en = e; din = d; load = ld; flush = fl; delay_sel = s;
    @(posedge clk); #1;
    en = 0; load = 0; flush = 0;
  endtask

  initial begin
    rst_n = 0; en = 0; din = '0; load = 0; flush = 0; delay_sel = '0;
    #2;
    chk = 1;
    check("reset_dout", 32'(dout), 32'h0);
    check("reset_valid", 32'(dout_valid), 32'h0);
    check("reset_primed", 32'(primed), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Default delay 64, continuous strobe, then a mid-stream load of 16.
    for (int k = 0; k < 131; k++) begin
      if (k == 100) cyc(1, DW'(k), 1, 0, 7'd16);
      else cyc(1, DW'(k), 0, 0, '0);
      if (k == 62) check("primed_before_63", 32'(primed), 32'h0);
      if (k == 63) begin
        check("primed_after_63", 32'(primed), 32'h1);
        check("valid_after_63", 32'(dout_valid), 32'h0);
      end
      if (k == 64) begin
        check("first_valid_64", 32'(dout_valid), 32'h1);
        check("first_dout_64", 32'(dout), 32'h0);
      end
      if (k == 99) check("dout_99", 32'(dout), 32'd35);
      if (k >= 100 && k <= 115) check("reload_quiet", 32'(dout_valid), 32'h0);
      if (k == 116) begin
        check("reload_first_valid", 32'(dout_valid), 32'h1);
        check("reload_first_dout", 32'(dout), 32'd100);
      end
    end

    // N=4 with a strobe every third cycle.
    cyc(0, '0, 1, 0, 7'd4);
    for (int i = 0; i < 6; i++) begin
      cyc(1, DW'(10 + i), 0, 0, '0);
      if (i < 4) check("n4_quiet", 32'(dout_valid), 32'h0);
      if (i == 4) begin
        check("n4_first_valid", 32'(dout_valid), 32'h1);
        check("n4_first_dout", 32'(dout), 32'd10);
      end
      for (int j = 0; j < 2; j++) begin
        cyc(0, '0, 0, 0, '0);
        check("n4_idle_valid", 32'(dout_valid), 32'h0);
        if (i == 4) check("n4_idle_hold", 32'(dout), 32'd10);
      end
    end

    // delay_sel=0 selects N=1; delay_sel=100 clamps to 64.
    cyc(0, '0, 1, 0, 7'd0);
    cyc(1, 16'h0111, 0, 0, '0);
    check("n1_quiet", 32'(dout_valid), 32'h0);
    cyc(1, 16'h0222, 0, 0, '0);
    check("n1_valid", 32'(dout_valid), 32'h1);
    check("n1_dout", 32'(dout), 32'h0111);
    cyc(0, '0, 1, 0, 7'd100);
    for (int i = 0; i < 65; i++) begin
      cyc(1, DW'(16'h4000 + i), 0, 0, '0);
      if (i == 63) check("clamp_quiet", 32'(dout_valid), 32'h0);
    end
    check("clamp_valid", 32'(dout_valid), 32'h1);
    check("clamp_dout", 32'(dout), 32'h4000);

    // Flush coincident with a strobe while running at N=8.
    cyc(0, '0, 1, 0, 7'd8);
    for (int i = 0; i < 20; i++) cyc(1, DW'($urandom), 0, 0, '0);
    cyc(1, 16'hABCD, 0, 1, '0);
    check("flush_quiet0", 32'(dout_valid), 32'h0);
    for (int i = 1; i <= 8; i++) begin
      cyc(1, DW'(16'h5000 + i), 0, 0, '0);
      if (i < 8) check("flush_quiet", 32'(dout_valid), 32'h0);
    end
    check("flush_valid", 32'(dout_valid), 32'h1);
    check("flush_dout", 32'(dout), 32'hABCD);

    // Asynchronous reset between edges while running.
    for (int i = 0; i < 4; i++) cyc(1, DW'(16'h6000 + i), 0, 0, '0);
    check("pre_areset_valid", 32'(dout_valid), 32'h1);
    #2 rst_n = 0;
    #1;
    check("areset_dout", 32'(dout), 32'h0);
    check("areset_valid", 32'(dout_valid), 32'h0);
    check("areset_primed", 32'(primed), 32'h0);
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 65; i++) begin
      cyc(1, DW'(16'h7000 + i), 0, 0, '0);
      if (i == 63) check("refill_quiet", 32'(dout_valid), 32'h0);
    end
    check("refill_valid", 32'(dout_valid), 32'h1);
    check("refill_dout", 32'(dout), 32'h7000);

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int i = 0; i < 4000; i++) begin
      logic e, ld, fl;
      e  = ($urandom_range(0, 99) < 60);
      ld = ($urandom_range(0, 99) < 2);
      fl = ($urandom_range(0, 99) < 2);
      cyc(e, DW'($urandom), ld, fl, NW'($urandom_range(0, 15) < 4 ? $urandom_range(0, 127)
                                                               : $urandom_range(1, 12)));
    end

    chk = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
